iir_boxcar_decimator: RTL and testbench
=======================================

Name: iir_boxcar_decimator

Overview:
Output stage placed directly downstream of the simple IIR biquad (DF1). It consumes the filter's signed 16-bit output stream and averages each block of DECIM consecutive samples (boxcar average). It decimates the result by DECIM and buffers the averaged samples in a small first-word-fall-through FIFO. A valid/ready handshake delivers them to the consumer, e.g. a UART/DAC packer.

Parameters:
DATA_W, 16, sample width (signed two's complement) for din and dout
DECIM, 4, decimation ratio; power of two, legal range 2..64
LOG2_DECIM, 2, log2(DECIM); must match DECIM
FIFO_DEPTH, 4, output FIFO entries; power of two, legal range 2..16

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
din_valid  in  1  din carries a new filter output sample this cycle
din  in  DATA_W  signed sample from biquad dout
dout  out  DATA_W  signed decimated sample at FIFO head
dout_valid  out  1  FIFO non-empty; dout holds valid data
dout_ready  in  1  consumer accepts dout this cycle
fifo_level  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy
overflow  out  1  sticky flag: a decimated result was dropped because the FIFO was full

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following, all synchronously: accumulator=0, sample counter=0, FIFO pointers and level=0, overflow=0. Outputs after reset: dout=0, dout_valid=0, fifo_level=0, overflow=0. Reset takes priority over all other activity. A partial block that is in progress is discarded.
- Accumulator: signed, DATA_W+LOG2_DECIM bits. It cannot overflow.
- Accept: on every edge with din_valid=1, the block adds din to the accumulator and increments the counter (0..DECIM-1). With din_valid=0, accumulator and counter hold. Gaps of any length between samples are legal.
- Block completion happens on an accepted sample when counter==DECIM-1:
  - sum = acc + din.
  - result = sum >>> LOG2_DECIM. This is an arithmetic shift with floor toward -inf, no rounding. The result always fits in DATA_W with no saturation.
  - On that same edge the accumulator resets to 0 and the counter resets to 0. The next accepted sample starts a new block, so no sample is lost.
  - On that same edge the result is pushed into the FIFO, if space allows.
- Latency: the result is visible on dout with dout_valid=1 in the cycle after the edge that accepted the DECIM-th sample, provided the FIFO was empty.
- FIFO is first-word-fall-through:
  - dout = head entry when dout_valid=1.
  - dout is forced to 0 when dout_valid=0.
  - dout_valid = (fifo_level != 0).
- Pop: occurs on an edge where dout_valid=1 and dout_ready=1. dout_ready while empty has no effect.
- Push rules:
  - Push succeeds if fifo_level<FIFO_DEPTH, or if fifo_level==FIFO_DEPTH and a pop occurs on the same edge.
  - Simultaneous push and pop leaves fifo_level unchanged. In that case the pushed value lands behind the remaining entries.
  - If push is attempted while full and there is no pop, the result is dropped, FIFO contents are unchanged, and overflow is set to 1.
- overflow stays at 1 until reset. Accumulation continues normally after a drop.
- Order is strictly preserved. dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is tracked separately, so full and empty are never ambiguous.
- No combinational path from din or din_valid to dout or dout_valid. The only combinational path is from dout_ready to nothing; pop affects state at the edge only.

Test Plan:
All scenarios use the defaults (DECIM=4, FIFO_DEPTH=4).
- Basic average: din 100,200,300,400 on consecutive cycles with dout_ready=1 -> one cycle later dout=250 and dout_valid=1 for one cycle; fifo_level returns to 0.
- Rounding and extremes:
  - -1,-1,-1,-2 -> dout=-2 (sum -5 floored).
  - 4×32767 -> 32767.
  - 4×-32768 -> -32768.
  - 1,1,1,0 -> 0.
- Gapped input: the same 100..400 sequence with din_valid=0 for 3 cycles between samples -> single output 250; no output before the 4th accepted sample.
- Backpressure/overflow:
  - Hold dout_ready=0 and feed 20 samples (5 blocks, values k*10 for block k=1..5) -> fifo_level=4, dout=10, overflow=1.
  - Then drain with dout_ready=1 -> outputs 10,20,30,40; the 5th result is lost.
- Full with simultaneous pop: FIFO full (10,20,30,40), 5th block completes on the same edge as a pop -> no overflow, fifo_level stays 4, drain order 20,30,40,50.
- Reset mid-operation:
  - Feed 2 samples of 1000, pulse rst_n=0 for one cycle, then feed 4 samples of 8 -> single output 8.
  - All outputs read 0 in the cycle after reset; overflow cleared.

Source files
------------

// File: rtl/iir_boxcar_decimator.sv
// iir_boxcar_decimator: boxcar-average and decimate a signed sample stream into a FWFT output FIFO
//   clk, rst_n      : clock, synchronous active-low reset
//   din_valid, din  : incoming signed samples from the biquad
//   dout, dout_valid, dout_ready : FWFT FIFO head with valid/ready handshake (dout=0 when empty)
//   fifo_level      : current FIFO occupancy
//   overflow        : sticky, set when a block result was dropped on a full FIFO
module iir_boxcar_decimator #(
  parameter int DATA_W     = 16,
  parameter int DECIM      = 4,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              din_valid,
  input  logic [DATA_W-1:0]                 din,
  output logic [DATA_W-1:0]                 dout,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow
);
  localparam int AW = DATA_W + LOG2_DECIM;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  logic signed [AW-1:0] acc, sum;
  logic [LOG2_DECIM-1:0] cnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] res;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic done, pop, push_ok;
  always_comb begin
    sum = acc + {{LOG2_DECIM{din[DATA_W-1]}}, din};
    res = DATA_W'(sum >>> LOG2_DECIM);
    done = din_valid && (&cnt);
    pop = dout_valid && dout_ready;
    // a full FIFO still accepts when its head leaves on the same edge
    push_ok = done && (fifo_level < FULL || pop);
    level_nxt = (push_ok && !pop) ? fifo_level + LW'(1) :
                (!push_ok && pop) ? fifo_level - LW'(1) : fifo_level;
  end
  assign dout_valid = fifo_level != '0;
  assign dout = dout_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
    end else begin
      if (din_valid) begin
        acc <= done ? '0 : sum;
        cnt <= cnt + LOG2_DECIM'(1);
      end
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (done && !push_ok) overflow <= 1'b1;
      fifo_level <= level_nxt;
    end
  end
  // when full with a simultaneous pop, wr_ptr equals rd_ptr, so the new entry replaces the departing head slot
  always_ff @(posedge clk) if (push_ok) mem[wr_ptr] <= res;
endmodule

// File: tb/tb_iir_boxcar_decimator.sv
// tb_iir_boxcar_decimator: directed self-checking bench for iir_boxcar_decimator
module tb_iir_boxcar_decimator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_valid = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic dout_valid;
  logic dout_ready = 1'b0;
  logic [2:0] fifo_level;
  logic overflow;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  iir_boxcar_decimator dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] v);
    din_valid = 1'b1;
    din = v;
    tick();
    din_valid = 1'b0;
  endtask
  task automatic block(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_dout"}, dout, 16'd0);
    chk({tag, "_valid"}, 16'(dout_valid), 16'd0);
    chk({tag, "_level"}, 16'(fifo_level), 16'd0);
    chk({tag, "_ovf"}, 16'(overflow), 16'd0);
  endtask
  initial begin
    tick();
    do_reset();
    chk_idle("reset");
    dout_ready = 1'b1;
    block(16'd100, 16'd200, 16'd300, 16'd400);
    chk("basic_dout", dout, 16'd250);
    chk("basic_valid", 16'(dout_valid), 16'd1);
    chk("basic_level", 16'(fifo_level), 16'd1);
    tick();
    chk("basic_popped_valid", 16'(dout_valid), 16'd0);
    chk("basic_popped_level", 16'(fifo_level), 16'd0);
    block(16'(-1), 16'(-1), 16'(-1), 16'(-2));
    chk("floor_m5", dout, 16'(-2));
    tick();
    block(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    chk("max_pos", dout, 16'h7FFF);
    tick();
    block(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    chk("max_neg", dout, 16'h8000);
    tick();
    block(16'd1, 16'd1, 16'd1, 16'd0);
    chk("floor_3", dout, 16'd0);
    chk("floor_3_valid", 16'(dout_valid), 16'd1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      send(16'(i * 100));
      if (i < 4) begin
        for (int g = 0; g < 3; g++) begin
          chk($sformatf("gap_novalid_%0d_%0d", i, g), 16'(dout_valid), 16'd0);
          tick();
        end
      end
    end
    chk("gap_dout", dout, 16'd250);
    chk("gap_valid", 16'(dout_valid), 16'd1);
    tick();
    chk("gap_single", 16'(dout_valid), 16'd0);
    dout_ready = 1'b0;
    for (int k = 1; k <= 5; k++) block(16'(k * 10), 16'(k * 10), 16'(k * 10), 16'(k * 10));
    chk("ovf_level", 16'(fifo_level), 16'd4);
    chk("ovf_head", dout, 16'd10);
    chk("ovf_flag", 16'(overflow), 16'd1);
    tick();
    chk("ovf_stable_head", dout, 16'd10);
    dout_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_drain_%0d", k), dout, 16'(k * 10));
      tick();
    end
    chk("ovf_drained", 16'(dout_valid), 16'd0);
    chk("ovf_sticky", 16'(overflow), 16'd1);
    do_reset();
    chk_idle("reset2");
    dout_ready = 1'b0;
    for (int k = 1; k <= 4; k++) block(16'(k * 10), 16'(k * 10), 16'(k * 10), 16'(k * 10));
    chk("sim_full", 16'(fifo_level), 16'd4);
    send(16'd50);
    send(16'd50);
    send(16'd50);
    dout_ready = 1'b1;
    send(16'd50);
    chk("sim_level", 16'(fifo_level), 16'd4);
    chk("sim_ovf", 16'(overflow), 16'd0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("sim_drain_%0d", k), dout, 16'(k * 10));
      tick();
    end
    chk("sim_empty", 16'(dout_valid), 16'd0);
    dout_ready = 1'b0;
    block(16'd5, 16'd5, 16'd5, 16'd5);
    chk("pre_rst_valid", 16'(dout_valid), 16'd1);
    send(16'd1000);
    send(16'd1000);
    do_reset();
    chk_idle("rst_mid");
    dout_ready = 1'b1;
    block(16'd8, 16'd8, 16'd8, 16'd8);
    chk("rst_mid_dout", dout, 16'd8);
    chk("rst_mid_level", 16'(fifo_level), 16'd1);
    tick();
    chk("rst_mid_single", 16'(dout_valid), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
